spi_master_byte: RTL and testbench
==================================

Name: spi_master_byte

Overview:
- Byte-level SPI master (mode 0, MSB first) between the memory controller and the external SPI memory pins.
- The memory controller presents one byte plus a start pulse. This block shifts the byte out on MOSI, shifts one byte in from MISO, then pulses done.
- Chip select can be held across consecutive bytes, so the controller can build a multi-byte command/address/data transaction.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- tx_data  input  8  byte to transmit; sampled only on an accepted start
- start  input  1  request a byte transfer; accepted only when busy=0
- cs_keep  input  1  sampled with start; 1 = keep spi_cs_n low after this byte
- cs_release  input  1  when idle with spi_cs_n low, release chip select
- rx_data  output  8  byte received; valid from the done cycle until the next accepted start
- done  output  1  one-cycle pulse at end of byte
- busy  output  1  high from the cycle after an accepted start/release until ready
- spi_sck  output  1  SPI clock, idle low
- spi_mosi  output  1  serial data out
- spi_miso  input  1  serial data in
- spi_cs_n  output  1  chip select, active low

Behaviour:
- Clock and reset: clk, rst_n. Reset is synchronous and active-low.
- Reset values: rx_data=0x00, done=0, busy=0, spi_sck=0, spi_mosi=0, spi_cs_n=1, state=IDLE.
- Reset asserted mid-transfer aborts the byte. All outputs take their reset values at the next edge, and no done pulse is issued.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, CS_GAP. A half-period counter counts CLK_DIV cycles per state step.
- Transfer timing (start accepted at edge 0):
  - IDLE with start=1 and busy=0: latch tx_data and cs_keep. At cycle 1: spi_cs_n=0, spi_mosi=bit7, busy=1, state=SETUP.
  - SETUP lasts CLK_DIV cycles. It always applies, even when CS was already held low.
  - spi_sck rises at cycle 1+CLK_DIV*(2k+1), k=0..7, entering SHIFT_HI. spi_miso is sampled into the shift register on the same clk edge that drives spi_sck high.
  - spi_sck falls at cycle 1+CLK_DIV*(2k+2), entering SHIFT_LO. On falling edges 1..7, spi_mosi advances to the next lower bit.
  - Last falling edge (cycle 1+16*CLK_DIV): done=1 for that cycle only; rx_data updated in the same cycle. With CLK_DIV=2, done occurs at cycle 33.
- End of byte:
  - Latched cs_keep=1: next cycle busy=0, spi_cs_n stays 0, spi_mosi=0, state=IDLE.
  - Latched cs_keep=0: next cycle spi_cs_n=1, state=CS_GAP for CLK_DIV cycles with busy=1, then busy=0 and state=IDLE. This guarantees a minimum CS-high time.
- cs_release:
  - In IDLE with spi_cs_n=0 and start=0: spi_cs_n=1 and enter CS_GAP (same timing as above).
  - Ignored in IDLE when spi_cs_n is already 1, and ignored while busy.
  - If start and cs_release are both high in IDLE, start wins and cs_release is ignored.
- start while busy=1 is ignored; tx_data and cs_keep are not re-latched.
- start is accepted in the same cycle busy returns to 0, allowing back-to-back bytes.
- CLK_DIV=1: one clk per half-period; same sequencing, done at cycle 17.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: the shift register samples spi_mosi internally instead of spi_miso, so rx_data equals the transmitted byte. spi_miso is unused. Pins still toggle normally.
- Undefined: spi_miso is sampled as described.

Test Plan:
- Reset with CLK_DIV=2 -> spi_cs_n=1, spi_sck=0, busy=0, done=0, rx_data=0x00. Then start with tx_data=0xA5 and cs_keep=0 while the slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 valid at each rising edge, 8 SCK pulses, done at cycle 33, rx_data=0x3C, spi_cs_n high at cycle 34, busy low at cycle 36.
- Two bytes, first with cs_keep=1 (0x03), second with cs_keep=0 (0xFF), second start issued on the first cycle busy=0 -> spi_cs_n stays low continuously across both bytes, 16 SCK pulses total, two done pulses, spi_cs_n high after the second byte.
- start pulsed repeatedly mid-transfer with a different tx_data=0x11 -> ignored; the original byte shifts out unchanged and exactly one done pulse is issued.
- rst_n asserted after 4 SCK pulses -> next cycle spi_cs_n=1, spi_sck=0, busy=0, no done pulse. A new transfer then completes normally.
- Byte with cs_keep=1, then cs_release while idle -> spi_cs_n=1 next cycle, busy high for CLK_DIV cycles, then low. cs_release with spi_cs_n=1 -> no effect.
- CLK_DIV=1 with SPI_LOOPBACK_EN defined, tx_data=0x5A -> done at cycle 17, rx_data=0x5A regardless of spi_miso.

Source files
------------

// File: rtl/spi_master_byte.sv
// Byte-level SPI master, mode 0, MSB first, with optional chip-select hold across bytes.
// Build option: define SPI_LOOPBACK_EN to sample spi_mosi internally instead of spi_miso.
module spi_master_byte #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       start,
   input  logic       cs_keep,
   input  logic       cs_release,
   output logic [7:0] rx_data,
   output logic       done,
   output logic       busy,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned BIT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(8);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      CS_GAP
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
   logic [7:0]       tx_sh, tx_sh_d;
   logic [7:0]       rx_sh, rx_sh_d;
   logic [7:0]       rx_data_d;
   logic             keep, keep_d;
   logic             done_d, busy_d, sck_d, mosi_d, cs_n_d;
   logic             sample_bit;
   logic             half_done;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = spi_miso;
   assign sample_bit  = spi_mosi;
`else
   assign sample_bit  = spi_miso;
`endif

   assign half_done = (cnt == CNT_LAST);

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      cnt_d     = cnt + CNT_W'(1);
      bit_cnt_d = bit_cnt;
      tx_sh_d   = tx_sh;
      rx_sh_d   = rx_sh;
      rx_data_d = rx_data;
      keep_d    = keep;
      done_d    = 1'b0;
      busy_d    = busy;
      sck_d     = spi_sck;
      mosi_d    = spi_mosi;
      cs_n_d    = spi_cs_n;

      case (state)
         IDLE: begin
            cnt_d = '0;
            if (start && !busy) begin
               // start has priority over cs_release
               tx_sh_d   = {tx_data[6:0], 1'b0};
               mosi_d    = tx_data[7];
               keep_d    = cs_keep;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               state_d   = SETUP;
            end else if (cs_release && !spi_cs_n) begin
               cs_n_d  = 1'b1;
               busy_d  = 1'b1;
               state_d = CS_GAP;
            end
         end

         SETUP, SHIFT_LO: begin
            if (state == SHIFT_LO && bit_cnt == BITS_ALL) begin
               // one-cycle tail after the last falling edge
               cnt_d  = '0;
               mosi_d = 1'b0;
               if (keep) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  cs_n_d  = 1'b1;
                  state_d = CS_GAP;
               end
            end else if (half_done) begin
               cnt_d     = '0;
               sck_d     = 1'b1;
               rx_sh_d   = {rx_sh[6:0], sample_bit};
               bit_cnt_d = bit_cnt + BIT_W'(1);
               state_d   = SHIFT_HI;
            end
         end

         SHIFT_HI: begin
            if (half_done) begin
               cnt_d   = '0;
               sck_d   = 1'b0;
               state_d = SHIFT_LO;
               if (bit_cnt == BITS_ALL) begin
                  done_d    = 1'b1;
                  rx_data_d = rx_sh;
               end else begin
                  mosi_d  = tx_sh[7];
                  tx_sh_d = {tx_sh[6:0], 1'b0};
               end
            end
         end

         CS_GAP: begin
            if (half_done) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               mosi_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         keep     <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
         spi_cs_n <= 1'b1;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         bit_cnt  <= bit_cnt_d;
         tx_sh    <= tx_sh_d;
         rx_sh    <= rx_sh_d;
         rx_data  <= rx_data_d;
         keep     <= keep_d;
         done     <= done_d;
         busy     <= busy_d;
         spi_sck  <= sck_d;
         spi_mosi <= mosi_d;
         spi_cs_n <= cs_n_d;
      end
   end

endmodule

// File: tb/tb_spi_master_byte.sv
// Testbench for spi_master_byte: CLK_DIV=2 instance (a) and CLK_DIV=1 instance (b) with SPI slave models.
module tb_spi_master_byte;

   localparam int unsigned DA = 2;
   localparam int unsigned DB = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [7:0] tx_a, rx_a;
   logic       start_a, keep_a, rel_a, done_a, busy_a, sck_a, mosi_a, miso_a, csn_a;
   logic [7:0] tx_b, rx_b;
   logic       start_b, keep_b, rel_b, done_b, busy_b, sck_b, mosi_b, miso_b, csn_b;

   int checks = 0;
   int fails  = 0;

   spi_master_byte #(.CLK_DIV(DA)) dut_a (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_a), .start(start_a), .cs_keep(keep_a),
      .cs_release(rel_a), .rx_data(rx_a), .done(done_a), .busy(busy_a),
      .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .spi_cs_n(csn_a)
   );

   spi_master_byte #(.CLK_DIV(DB)) dut_b (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_b), .start(start_b), .cs_keep(keep_b),
      .cs_release(rel_b), .rx_data(rx_b), .done(done_b), .busy(busy_b),
      .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b), .spi_cs_n(csn_b)
   );

   // Slave models: capture MOSI on each rising SCK, present the reply byte MSB first
   logic [7:0] slave_a = 8'h00, cap_a = 8'h00;
   logic [7:0] slave_b = 8'h00, cap_b = 8'h00;
   int rises_a = 0, base_a = 0, rises_b = 0, base_b = 0;

   always @(posedge sck_a) begin
      cap_a   <= {cap_a[6:0], mosi_a};
      rises_a <= rises_a + 1;
   end
   always @(posedge sck_b) begin
      cap_b   <= {cap_b[6:0], mosi_b};
      rises_b <= rises_b + 1;
   end

   assign miso_a = (rises_a - base_a < 8) ? slave_a[3'(7 - (rises_a - base_a))] : 1'b0;
   assign miso_b = (rises_b - base_b < 8) ? slave_b[3'(7 - (rises_b - base_b))] : 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One byte on instance a; cycle 1 is the first cycle after the accepting edge
   task automatic run_a(input logic [7:0] tx, input logic keep, input logic [7:0] reply,
                        input logic hammer,
                        output int done_cyc, output int csh_cyc, output int idle_cyc,
                        output int n_done, output logic [7:0] rx_seen,
                        output logic [7:0] mosi_seen, output int pulses, output logic cs_ok);
      int r0;
      int cyc;
      slave_a = reply;
      base_a  = rises_a;
      r0      = rises_a;
      tx_a    = tx;
      keep_a  = keep;
      start_a = 1'b1;
      tick();
      start_a  = 1'b0;
      tx_a     = 8'($urandom);
      keep_a   = 1'($urandom);
      cyc      = 1;
      done_cyc = -1;
      csh_cyc  = -1;
      idle_cyc = -1;
      n_done   = 0;
      rx_seen  = 8'h00;
      cs_ok    = 1'b1;
      while (idle_cyc < 0 && cyc < 400) begin
         if (done_a) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               rx_seen  = rx_a;
            end
         end
         if (done_cyc < 0 && csn_a) cs_ok = 1'b0;
         if (done_cyc >= 0 && csn_a && csh_cyc < 0) csh_cyc = cyc;
         if (!busy_a) begin
            idle_cyc = cyc;
         end else begin
            if (hammer) begin
               start_a = (cyc % 2 == 1);
               tx_a    = 8'h11;
               keep_a  = 1'b1;
            end
            tick();
            cyc++;
         end
      end
      start_a   = 1'b0;
      mosi_seen = cap_a;
      pulses    = rises_a - r0;
      if (idle_cyc < 0) begin
         fails++;
         $display("FAIL run_a timeout: busy still %0b after %0d cycles, required 0", busy_a, cyc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({csn_a, sck_a, busy_a, done_a, mosi_a, rx_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_a: cs_n/sck/busy/done/mosi/rx = %b%b%b%b%b/%h required 10000/00",
                  csn_a, sck_a, busy_a, done_a, mosi_a, rx_a);
      end
      checks++;
      if ({csn_b, sck_b, busy_b, done_b, rx_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_b: cs_n/sck/busy/done/rx = %b%b%b%b/%h required 1000/00",
                  csn_b, sck_b, busy_b, done_b, rx_b);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int dc, cc, ic, nd, np;
      logic [7:0] rx, mo;
      logic ok;
      run_a(8'hA5, 1'b0, 8'h3C, 1'b0, dc, cc, ic, nd, rx, mo, np, ok);
      checks++;
      if (dc !== int'(1 + 16 * DA)) begin fails++; $display("FAIL basic_done_cycle: got %0d required %0d", dc, 1 + 16 * DA); end
      checks++;
      if (rx !== 8'h3C) begin fails++; $display("FAIL basic_rx: got %h required 3c", rx); end
      checks++;
      if (mo !== 8'hA5) begin fails++; $display("FAIL basic_mosi: got %h required a5", mo); end
      checks++;
      if (np !== 8) begin fails++; $display("FAIL basic_pulses: got %0d required 8", np); end
      checks++;
      if (cc !== int'(2 + 16 * DA)) begin fails++; $display("FAIL basic_cs_high: got %0d required %0d", cc, 2 + 16 * DA); end
      checks++;
      if (ic !== int'(2 + 17 * DA)) begin fails++; $display("FAIL basic_busy_low: got %0d required %0d", ic, 2 + 17 * DA); end
      checks++;
      if (!ok || nd !== 1) begin fails++; $display("FAIL basic_cs_low_done: cs_ok %0b done pulses %0d required 1/1", ok, nd); end
      checks++;
      if (rx_a !== 8'h3C) begin fails++; $display("FAIL basic_rx_hold: got %h required 3c", rx_a); end
   endtask

   task automatic test_random();
      int dc, cc, ic, nd, np;
      logic [7:0] rx, mo, tx, rep;
      logic ok, kp;
      for (int i = 0; i < 6; i++) begin
         tx  = 8'($urandom);
         rep = 8'($urandom);
         kp  = 1'($urandom);
         run_a(tx, kp, rep, 1'b0, dc, cc, ic, nd, rx, mo, np, ok);
         checks++;
         if (rx !== rep || mo !== tx || np !== 8) begin
            fails++;
            $display("FAIL rand_data[%0d]: rx %h mosi %h pulses %0d required %h %h 8", i, rx, mo, np, rep, tx);
         end
         checks++;
         if (ic !== int'(kp ? 2 + 16 * DA : 2 + 17 * DA) || (kp && cc !== -1) || csn_a !== !kp) begin
            fails++;
            $display("FAIL rand_end[%0d]: idle %0d cs_high %0d cs_n %0b keep %0b", i, ic, cc, csn_a, kp);
         end
      end
      if (!csn_a) begin
         rel_a = 1'b1;
         tick();
         rel_a = 1'b0;
         repeat (DA + 2) tick();
      end
   endtask

   task automatic test_back_to_back();
      int dc1, cc1, ic1, nd1, np1, dc2, cc2, ic2, nd2, np2;
      logic [7:0] rx1, mo1, rx2, mo2;
      logic ok1, ok2, mid_cs;
      run_a(8'h03, 1'b1, 8'h81, 1'b0, dc1, cc1, ic1, nd1, rx1, mo1, np1, ok1);
      mid_cs = csn_a;
      run_a(8'hFF, 1'b0, 8'h42, 1'b0, dc2, cc2, ic2, nd2, rx2, mo2, np2, ok2);
      checks++;
      if (!ok1 || !ok2 || mid_cs !== 1'b0 || cc1 !== -1) begin
         fails++;
         $display("FAIL b2b_cs_continuous: ok %0b%0b mid cs_n %0b first cs_high %0d", ok1, ok2, mid_cs, cc1);
      end
      checks++;
      if (np1 + np2 !== 16 || nd1 + nd2 !== 2) begin
         fails++;
         $display("FAIL b2b_counts: pulses %0d dones %0d required 16 2", np1 + np2, nd1 + nd2);
      end
      checks++;
      if (rx1 !== 8'h81 || rx2 !== 8'h42 || mo1 !== 8'h03 || mo2 !== 8'hFF) begin
         fails++;
         $display("FAIL b2b_data: rx %h %h mosi %h %h required 81 42 03 ff", rx1, rx2, mo1, mo2);
      end
      checks++;
      if (cc2 !== int'(2 + 16 * DA) || csn_a !== 1'b1) begin
         fails++;
         $display("FAIL b2b_cs_release: cs_high %0d cs_n %0b required %0d 1", cc2, csn_a, 2 + 16 * DA);
      end
   endtask

   task automatic test_ignore_start();
      int dc, cc, ic, nd, np;
      logic [7:0] rx, mo;
      logic ok;
      run_a(8'h96, 1'b0, 8'h5E, 1'b1, dc, cc, ic, nd, rx, mo, np, ok);
      checks++;
      if (mo !== 8'h96 || nd !== 1 || np !== 8) begin
         fails++;
         $display("FAIL ignore_start: mosi %h dones %0d pulses %0d required 96 1 8", mo, nd, np);
      end
      checks++;
      if (cc !== int'(2 + 16 * DA) || ic !== int'(2 + 17 * DA)) begin
         fails++;
         $display("FAIL ignore_start_keep: cs_high %0d idle %0d required %0d %0d", cc, ic, 2 + 16 * DA, 2 + 17 * DA);
      end
   endtask

   task automatic test_reset_mid();
      int n, nd;
      int dc, cc, ic, np;
      logic [7:0] rx, mo;
      logic ok;
      slave_a = 8'hF0;
      base_a  = rises_a;
      tx_a    = 8'hC7;
      keep_a  = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      n = 0;
      while (rises_a - base_a < 4 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (rises_a - base_a < 4) begin fails++; $display("FAIL reset_mid_wait: pulses %0d required 4", rises_a - base_a); end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({csn_a, sck_a, busy_a, done_a, rx_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_mid: cs_n/sck/busy/done/rx = %b%b%b%b/%h required 1000/00",
                  csn_a, sck_a, busy_a, done_a, rx_a);
      end
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_a || busy_a) nd++;
         tick();
      end
      checks++;
      if (nd !== 0) begin fails++; $display("FAIL reset_mid_quiet: %0d active cycles required 0", nd); end
      run_a(8'h3A, 1'b0, 8'hE1, 1'b0, dc, cc, ic, nd, rx, mo, np, ok);
      checks++;
      if (rx !== 8'hE1 || mo !== 8'h3A || dc !== int'(1 + 16 * DA)) begin
         fails++;
         $display("FAIL reset_mid_recover: rx %h mosi %h done %0d required e1 3a %0d", rx, mo, dc, 1 + 16 * DA);
      end
   endtask

   task automatic test_cs_release();
      int dc, cc, ic, nd, np, n;
      logic [7:0] rx, mo;
      logic ok;
      run_a(8'h9B, 1'b1, 8'h27, 1'b0, dc, cc, ic, nd, rx, mo, np, ok);
      // start and cs_release together: start must win, release ignored while busy
      rel_a = 1'b1;
      run_a(8'h64, 1'b1, 8'hD2, 1'b0, dc, cc, ic, nd, rx, mo, np, ok);
      rel_a = 1'b0;
      checks++;
      if (!ok || cc !== -1 || csn_a !== 1'b0 || mo !== 8'h64) begin
         fails++;
         $display("FAIL start_over_release: cs_ok %0b cs_high %0d cs_n %0b mosi %h required 1 -1 0 64", ok, cc, csn_a, mo);
      end
      rel_a = 1'b1;
      tick();
      rel_a = 1'b0;
      checks++;
      if (csn_a !== 1'b1 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL release_enter: cs_n %0b busy %0b required 1 1", csn_a, busy_a);
      end
      n = 0;
      while (busy_a && n < 50) begin
         n++;
         tick();
      end
      checks++;
      if (n !== int'(DA)) begin fails++; $display("FAIL release_gap: busy %0d cycles required %0d", n, DA); end
      rel_a = 1'b1;
      tick();
      rel_a = 1'b0;
      checks++;
      if (csn_a !== 1'b1 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL release_noop: cs_n %0b busy %0b required 1 0", csn_a, busy_a);
      end
   endtask

   task automatic test_clkdiv1();
      int cyc, dc;
      logic [7:0] rx, exp_rx;
`ifdef SPI_LOOPBACK_EN
      exp_rx = 8'h5A;
`else
      exp_rx = 8'hC3;
`endif
      slave_b = 8'hC3;
      base_b  = rises_b;
      tx_b    = 8'h5A;
      keep_b  = 1'b0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      cyc = 1;
      dc  = -1;
      rx  = 8'h00;
      while (dc < 0 && cyc < 100) begin
         if (done_b) begin
            dc = cyc;
            rx = rx_b;
         end else begin
            tick();
            cyc++;
         end
      end
      checks++;
      if (dc !== int'(1 + 16 * DB)) begin fails++; $display("FAIL div1_done_cycle: got %0d required %0d", dc, 1 + 16 * DB); end
      checks++;
      if (rx !== exp_rx || cap_b !== 8'h5A) begin
         fails++;
         $display("FAIL div1_data: rx %h mosi %h required %h 5a", rx, cap_b, exp_rx);
      end
      repeat (DB + 3) tick();
   endtask

   initial begin
      rst_n   = 1'b0;
      tx_a    = 8'h00; start_a = 1'b0; keep_a = 1'b0; rel_a = 1'b0;
      tx_b    = 8'h00; start_b = 1'b0; keep_b = 1'b0; rel_b = 1'b0;
      test_reset();
      test_basic();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_cs_release();
      test_clkdiv1();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
